// File: rtl/prbs_checker_pkg.sv
// Shared types and defaults for the RX-side PRBS bit-error checker.
package prbs_checker_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } CHECKER_STATE;

  // PRBS7 (x^7 + x^6 + 1), identical to the TX-side generator
  localparam int unsigned PRBS_N_DEF       = 7;
  localparam int unsigned PRBS_TAP_DEF     = 6;
  localparam int unsigned BIT_CNT_W_DEF    = 48;
  localparam int unsigned ERR_CNT_W_DEF    = 32;
  localparam int unsigned FILTER_OUT_WIDTH = 16;

  function automatic logic slice_bit(input logic signed [FILTER_OUT_WIDTH-1:0] s,
                                     input logic inv);
    return (~s[FILTER_OUT_WIDTH-1]) ^ inv;
  endfunction

endpackage

// File: rtl/prbs_checker_lfsr.sv
// Loadable Fibonacci LFSR: shifts in the received bit while seeding, its own prediction otherwise.
module prbs_lfsr
  import prbs_checker_pkg::*;
#(
  parameter int unsigned N   = PRBS_N_DEF,
  parameter int unsigned TAP = PRBS_TAP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load_mode,
  input  logic in_bit,
  output logic exp_bit,
  output logic all_zero
);

  logic [N-1:0] s_q, s_d;

  assign exp_bit  = s_q[N-1] ^ s_q[TAP-1];
  assign all_zero = (s_q == '0);

  always_comb begin
    s_d = s_q;
    if (en) begin
      s_d = {s_q[N-2:0], (load_mode ? in_bit : exp_bit)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// RX BER monitor: slices the channel output, self-syncs a PRBS LFSR and counts bits/errors.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int unsigned PRBS_N     = PRBS_N_DEF,
  parameter int unsigned PRBS_TAP   = PRBS_TAP_DEF,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned WIN_LEN    = 1024,
  parameter int unsigned UNLOCK_ERR = 32,
  parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF,
  parameter int unsigned ERR_CNT_W  = ERR_CNT_W_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cke,
  input  logic signed [FILTER_OUT_WIDTH-1:0] sig_in,
  input  logic                               invert,
  input  logic                               clear,
  output logic                               locked,
  output logic                               err_pulse,
  output logic [BIT_CNT_W-1:0]               bit_count,
  output logic [ERR_CNT_W-1:0]               err_count
);

  localparam int unsigned SEED_W  = $clog2(PRBS_N + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned WERR_W  = $clog2(UNLOCK_ERR + 1);

  CHECKER_STATE         state_q, state_d;
  logic [SEED_W-1:0]    seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]    win_err_q, win_err_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_pulse_q, err_pulse_d;

  logic rx_bit, exp_bit, lfsr_zero, lfsr_en, lfsr_load, mismatch;

  assign rx_bit   = slice_bit(sig_in, invert);
  assign mismatch = rx_bit ^ exp_bit;

  prbs_lfsr #(
    .N   (PRBS_N),
    .TAP (PRBS_TAP)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (lfsr_en),
    .load_mode (lfsr_load),
    .in_bit    (rx_bit),
    .exp_bit   (exp_bit),
    .all_zero  (lfsr_zero)
  );

  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    lfsr_en     = 1'b0;
    lfsr_load   = 1'b0;

    if (cke) begin
      unique case (state_q)
        SEED: begin
          lfsr_en   = 1'b1;
          lfsr_load = 1'b1;
          if (seed_cnt_q == SEED_W'(PRBS_N - 1)) begin
            state_d     = VERIFY;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end

        VERIFY: begin
          // A mismatching sample is dropped: the LFSR is not advanced.
          if (mismatch || lfsr_zero) begin
            state_d    = SEED;
            seed_cnt_d = '0;
          end else begin
            lfsr_en = 1'b1;
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
              bit_cnt_d   = '0;
              err_cnt_d   = '0;
              win_cnt_d   = '0;
              win_err_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end
        end

        LOCKED: begin
          lfsr_en = 1'b1;
          if (!clear) begin
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
            if (mismatch) begin
              err_pulse_d = 1'b1;
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end
          end
          // The window error count ignores clear; only the window wrap resets it.
          if (mismatch && (win_err_q == WERR_W'(UNLOCK_ERR - 1))) begin
            state_d    = SEED;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WIN_W'(WIN_LEN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_q + WERR_W'(mismatch);
          end
        end

        default: state_d = SEED;
      endcase
    end

    if (clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign bit_count = bit_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed/randomized bench for prbs_checker against a sample-level behavioural model.
module tb_prbs_checker;
  import prbs_checker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cke, invert, clear;
  logic signed [FILTER_OUT_WIDTH-1:0] sig_in;
  logic        locked, err_pulse;
  logic [47:0] bit_count;
  logic [31:0] err_count;
  logic        s_locked, s_err_pulse;
  logic [47:0] s_bit_count;
  logic [3:0]  s_err_count;

  prbs_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cke       (cke),
    .sig_in    (sig_in),
    .invert    (invert),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .bit_count (bit_count),
    .err_count (err_count)
  );

  prbs_checker #(.ERR_CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .cke       (cke),
    .sig_in    (sig_in),
    .invert    (invert),
    .clear     (clear),
    .locked    (s_locked),
    .err_pulse (s_err_pulse),
    .bit_count (s_bit_count),
    .err_count (s_err_count)
  );

  int checks = 0;
  int errors = 0;

  // Transmitted PRBS7 history (oldest first) and channel polarity.
  bit hist[$];
  bit chan_flip;

  // Behavioural model state.
  bit     m_locked, m_pulse;
  int     m_acq, m_wpos, m_werr;
  longint m_bits, m_errs;
  int     pulses_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_pulse = 0; m_acq = 0; m_wpos = 0; m_werr = 0;
    m_bits = 0; m_errs = 0;
  endtask

  task automatic model_sample(input bit corrupt, input bit clr);
    m_pulse = 0;
    if (!m_locked) begin
      if (corrupt || (chan_flip ^ invert)) m_acq = 0;
      else m_acq++;
      if (m_acq == 71) begin
        m_locked = 1; m_acq = 0; m_bits = 0; m_errs = 0; m_wpos = 0; m_werr = 0;
      end
    end else begin
      if (clr) begin
        m_bits = 0; m_errs = 0;
      end else begin
        m_bits++;
        if (corrupt) begin m_errs++; m_pulse = 1; end
      end
      if (corrupt) m_werr++;
      if (m_werr == 32) begin
        m_locked = 0; m_werr = 0;
      end else begin
        m_wpos = (m_wpos + 1) % 1024;
        if (m_wpos == 0) m_werr = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("locked", locked, m_locked);
    chk("err_pulse", err_pulse, m_pulse);
    chk("bit_count", bit_count, m_bits);
    chk("err_count", err_count, m_errs);
    chk("sat_locked", s_locked, m_locked);
    chk("sat_err_count", s_err_count, (m_errs > 15) ? 15 : m_errs);
  endtask

  task automatic next_bit(output bit b);
    b = hist[0] ^ hist[1];
    hist.push_back(b);
    void'(hist.pop_front());
  endtask

  task automatic drive_sample(input bit corrupt, input bit en = 1'b1, input bit clr = 1'b0);
    bit b, phys;
    int lim, v;
    lim = (1 << (FILTER_OUT_WIDTH - 1)) - 1;
    if (en) next_bit(b);
    else b = 1'($urandom_range(1, 0));
    phys = b ^ corrupt ^ chan_flip;
    if (phys) v = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(lim, 0));
    else v = -1 - int'($urandom_range(lim, 0));
    sig_in = FILTER_OUT_WIDTH'(v);
    cke    = en;
    clear  = clr;
    @(posedge clk); #1;
    if (en) model_sample(corrupt, clr);
    else m_pulse = 0;
    cke   = 1'b0;
    clear = 1'b0;
    check_all();
    if (err_pulse) pulses_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cke = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cke = 1'b0; clear = 1'b0; invert = 1'b0; sig_in = '0;
    chan_flip = 0;
    for (int i = 0; i < 7; i++) hist.push_back(1'b1);
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;

    // Clean stream, cke every cycle
    repeat (70) drive_sample(0);
    chk("not_locked_70", locked, 0);
    drive_sample(0);
    chk("locked_71", locked, 1);
    repeat (10000) drive_sample(0);
    chk("clean_bits", bit_count, 10000);
    chk("clean_errs", err_count, 0);

    // Isolated bit flips
    pulses_seen = 0;
    for (int i = 1; i <= 1000; i++) drive_sample((i == 100) || (i == 500) || (i == 900));
    chk("flip_pulses", pulses_seen, 3);
    chk("flip_errs", err_count, 3);
    chk("flip_locked", locked, 1);

    // 32 errors in one window force relock
    do_reset();
    repeat (71) drive_sample(0);
    chk("relock_base", locked, 1);
    for (int k = 0; k < 32; k++) begin
      repeat (4) drive_sample(0);
      drive_sample(1);
      if (k == 30) chk("locked_after_31", locked, 1);
    end
    chk("unlock_32", locked, 0);
    chk("unlock_errs", err_count, 32);
    repeat (70) drive_sample(0);
    chk("held_locked", locked, 0);
    chk("held_errs", err_count, 32);
    drive_sample(0);
    chk("relocked", locked, 1);
    chk("relock_errs", err_count, 0);
    chk("relock_bits", bit_count, 0);

    // Saturation of the narrow error counter
    for (int k = 0; k < 20; k++) begin
      repeat (2) drive_sample(0);
      drive_sample(1);
    end
    chk("sat_main_errs", err_count, 20);
    chk("sat_narrow_errs", s_err_count, 15);

    // Clear coincident with an error sample
    drive_sample(1, 1, 1);
    chk("clear_errs", err_count, 0);
    chk("clear_bits", bit_count, 0);
    chk("clear_pulse", err_pulse, 0);
    drive_sample(0);
    chk("post_clear_bits", bit_count, 1);

    // Asynchronous reset mid-lock
    repeat (3) drive_sample(1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_err_pulse", err_pulse, 0);
    chk("async_bits", bit_count, 0);
    chk("async_errs", err_count, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Polarity
    chan_flip = 1; invert = 1'b0;
    do_reset();
    repeat (300) drive_sample(0);
    chk("badpol_never", locked, 0);
    invert = 1'b1;
    do_reset();
    repeat (70) drive_sample(0);
    chk("inv_not_70", locked, 0);
    drive_sample(0);
    chk("inv_locked_71", locked, 1);

    // cke one cycle in four
    chan_flip = 0; invert = 1'b0;
    do_reset();
    for (int i = 0; i < 71; i++) begin
      repeat (3) drive_sample(0, 0);
      if (i == 70) chk("cke4_not_yet", locked, 0);
      drive_sample(0, 1);
    end
    chk("cke4_locked_284", locked, 1);
    for (int i = 0; i < 10; i++) begin
      repeat (3) drive_sample(0, 0);
      drive_sample(0, 1);
    end
    chk("cke4_bits", bit_count, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
